mmio_ctrl: RTL and testbench
============================

Name: mmio_ctrl

Overview:
- Sequences every MEM-stage access that falls in the MMIO window onto a single-outstanding peripheral bus with a req/ack handshake.
- Drives the d_valid/d_ready/d_rdata triple consumed by the MEM stage, stalls the pipeline while a transaction is in flight, and reports bus faults as an interrupt source.
- Sits between core_MEM and the peripheral interconnect; data memory stays untouched for MMIO addresses.

Parameters:
- MMIO_BASE, 64'h0000_2000, first byte address of the MMIO window (directly above data memory).
- MMIO_SIZE, 64'h0000_1000, window size in bytes; must be a power of two.
- TIMEOUT, 16, cycles in REQ/DRAIN without ack before a fault is declared; range 2..255.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- req_addr  in  64  MEM-stage effective address
- req_wdata  in  64  store data
- req_load_type  in  3  load width: 0 none, 1 byte, 2 half, 3 word, 4 dword
- req_store_type  in  3  store width, same encoding
- req_signed  in  1  sign-extend load data
- flush  in  1  squash the current MEM-stage instruction
- d_valid  out  1  combinational MMIO hit; gates data memory and selects d_rdata
- d_ready  out  1  response for the current MEM instruction is available
- d_rdata  out  64  extended load data
- stall  out  1  hold the pipeline: d_valid & ~d_ready, or a new hit while DRAIN is active
- bus_req  out  1  transaction request
- bus_we  out  1  1 = write
- bus_addr  out  64  byte address, 8-byte aligned
- bus_wdata  out  64  store data replicated into its byte lane
- bus_be  out  8  byte enables
- bus_ack  in  1  transaction complete
- bus_err  in  1  qualified by bus_ack: slave error
- bus_rdata  in  64  read data, valid with bus_ack
- bus_fault  out  1  one-cycle pulse to an interrupt_sources bit

Behaviour:
- Hit condition: (req_load_type | req_store_type) != 0 and MMIO_BASE <= req_addr < MMIO_BASE + MMIO_SIZE. d_valid = hit & ~flush.
- FSM states: IDLE, REQ, DONE, DRAIN. Reset puts the FSM in IDLE and clears all outputs, d_rdata and the timeout counter.
- IDLE: on d_valid, register addr, be, wdata and we, and go to REQ. Registered bus outputs assert the next cycle; stall = 1 from the hit cycle onward.
- REQ:
  - bus_req held at 1 and bus fields held stable until bus_ack.
  - On ack with no error: latch the extended rdata and go to DONE.
  - On ack with bus_err, or when the counter reaches TIMEOUT-1: d_rdata = all ones, pulse bus_fault, go to DONE.
  - On flush (no ack in the same cycle): go to DRAIN.
- DONE: exactly one cycle. d_ready = 1, stall = 0, d_rdata stable; then IDLE. A new hit is not accepted in DONE; it is taken next cycle in IDLE.
- DRAIN:
  - bus_req stays asserted until ack or timeout; the response is discarded and bus_fault is suppressed.
  - stall = 0 unless a new hit is present, in which case stall = 1.
  - Exit to IDLE.
- Flush together with ack in the same cycle: the response is discarded and the FSM returns to IDLE.
- Extension: byte offset = addr[2:0]. Load data is shifted down by offset*8, masked to width, and sign- or zero-extended per req_signed. Misaligned accesses use the low bits as given; no trap.
- Reset asserted mid-transaction aborts immediately. bus_req drops asynchronously; the slave must tolerate this.

Optional Feature:
- MMIO_TIMEOUT_EN
  - Defined: timeout counter present; REQ/DRAIN abort after TIMEOUT cycles as above.
  - Undefined: no counter; REQ/DRAIN wait indefinitely for bus_ack, and bus_fault comes only from bus_err.

Decomposition:
- Package structures:
  - mmio_state_t enum {IDLE, REQ, DONE, DRAIN}.
  - MEM_NONE/BYTE/HALF/WORD/DWORD localparams shared with data_mem.
- Sub-module mmio_extend: combinational shift, mask and sign-extend, plus generation of bus_be and the replicated wdata.

Test Plan:
- Load word signed at 64'h2004; slave acks after 3 cycles with 64'h8000_0000_0000_0000 >> 0, upper word 32'h8000_0001 -> stall high for 4 cycles, then d_ready for 1 cycle, d_rdata = 64'hFFFF_FFFF_8000_0001.
- Store byte 8'hA5 to 64'h2003 -> bus_we = 1, bus_be = 8'b0000_1000, bus_wdata[31:24] = 8'hA5, single REQ until ack.
- No ack, MMIO_TIMEOUT_EN defined, TIMEOUT = 16 -> bus_fault pulses once, d_rdata = all ones, FSM back in IDLE 17–18 cycles after the hit.
- Flush in the 2nd REQ cycle, ack 3 cycles later, and a new hit at 64'h2010 arrives meanwhile -> first response dropped, stall held, second transaction issued only after the ack.
- Load at 64'h1FF8 (data memory) -> d_valid = 0, stall = 0, no bus_req.
- Drop reset to 0 while in REQ -> bus_req, stall and d_ready go to 0 immediately; FSM is in IDLE after reset returns to 1.

Source files
------------

// File: rtl/mmio_ctrl_pkg.sv
//==============================================================================
// Module   : mmio_ctrl_pkg
// Purpose  : Shared types and constants for the MMIO controller slice.
//            - mmio_state_t : controller FSM states
//            - MEM_*        : access-width encoding shared with data_mem
//            - mem_byte_mask: access width -> right-aligned byte mask
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package mmio_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } mmio_state_t;

  localparam logic [2:0] MEM_NONE  = 3'd0;
  localparam logic [2:0] MEM_BYTE  = 3'd1;
  localparam logic [2:0] MEM_HALF  = 3'd2;
  localparam logic [2:0] MEM_WORD  = 3'd3;
  localparam logic [2:0] MEM_DWORD = 3'd4;

  // Byte mask for an access of the given width, before lane shifting.
  function automatic logic [7:0] mem_byte_mask(input logic [2:0] acc_type);
    logic [7:0] m;
    case (acc_type)
      MEM_BYTE:  m = 8'h01;
      MEM_HALF:  m = 8'h03;
      MEM_WORD:  m = 8'h0F;
      MEM_DWORD: m = 8'hFF;
      default:   m = 8'h00;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_ctrl_if.sv
//==============================================================================
// Module   : mmio_ctrl_if
// Purpose  : Single-outstanding peripheral bus with req/ack handshake.
// Ports    : master drives bus_req/bus_we/bus_addr/bus_wdata/bus_be and
//            receives bus_ack/bus_err/bus_rdata; slave is the mirror image.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

interface mmio_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_be;
  logic        bus_ack;
  logic        bus_err;
  logic [63:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_err, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_err, bus_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mmio_ctrl_extend.sv
//==============================================================================
// Module   : mmio_extend
// Purpose  : Combinational data alignment for MMIO accesses.
//            Load path : shift raw bus data down by the byte offset, mask to
//                        the access width, sign/zero extend.
//            Store path: byte enables and store data moved into its lane.
// Ports    : ld_type/ld_off/ld_signed/ld_raw -> ld_data
//            acc_type/acc_off/st_data        -> be, wdata_lane
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module mmio_extend
  import mmio_ctrl_pkg::*;
(
  input  logic [2:0]  ld_type,
  input  logic [2:0]  ld_off,
  input  logic        ld_signed,
  input  logic [63:0] ld_raw,
  output logic [63:0] ld_data,
  input  logic [2:0]  acc_type,
  input  logic [2:0]  acc_off,
  input  logic [63:0] st_data,
  output logic [7:0]  be,
  output logic [63:0] wdata_lane
);

  logic [63:0] ld_shift;
  logic [63:0] ld_mask;
  logic        ld_sign;
  logic [7:0]  st_bytes;
  logic [63:0] st_mask;

  always_comb begin
    ld_shift = ld_raw >> {ld_off, 3'b000};
    ld_mask  = 64'd0;
    ld_sign  = 1'b0;
    case (ld_type)
      MEM_BYTE:  begin ld_mask = 64'h0000_0000_0000_00FF; ld_sign = ld_shift[7];  end
      MEM_HALF:  begin ld_mask = 64'h0000_0000_0000_FFFF; ld_sign = ld_shift[15]; end
      MEM_WORD:  begin ld_mask = 64'h0000_0000_FFFF_FFFF; ld_sign = ld_shift[31]; end
      MEM_DWORD: begin ld_mask = {64{1'b1}};              ld_sign = ld_shift[63]; end
      default:   begin ld_mask = 64'd0;                   ld_sign = 1'b0;         end
    endcase
    // Misaligned loads simply lose the bytes shifted past bit 63.
    ld_data = (ld_signed && ld_sign) ? (ld_shift | ~ld_mask) : (ld_shift & ld_mask);
  end

  always_comb begin
    st_bytes = mem_byte_mask(acc_type);
    st_mask  = 64'd0;
    for (int i = 0; i < 8; i++) begin
      st_mask[i*8 +: 8] = {8{st_bytes[i]}};
    end
    // Bytes that would cross the 8-byte boundary are dropped.
    be         = st_bytes << acc_off;
    wdata_lane = (st_data & st_mask) << {acc_off, 3'b000};
  end

endmodule

`default_nettype wire

// File: rtl/mmio_ctrl.sv
//==============================================================================
// Module   : mmio_ctrl
// Purpose  : Sequences MEM-stage accesses in the MMIO window onto a
//            single-outstanding req/ack peripheral bus, stalls the pipeline
//            while a transaction is in flight and flags bus faults.
// Ports    : clock, reset (async, active low)
//            req_* / flush          : MEM-stage request
//            d_valid/d_ready/d_rdata: MEM-stage response, stall
//            bus (mmio_ctrl_if.master): peripheral bus
//            bus_fault              : one-cycle interrupt pulse
// Config   : MMIO_TIMEOUT_EN - when defined, REQ/DRAIN abort after TIMEOUT
//            cycles without ack; otherwise they wait indefinitely.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module mmio_ctrl
  import mmio_ctrl_pkg::*;
#(
  parameter logic [63:0] MMIO_BASE = 64'h0000_2000,
  parameter logic [63:0] MMIO_SIZE = 64'h0000_1000,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [2:0]  req_load_type,
  input  logic [2:0]  req_store_type,
  input  logic        req_signed,
  input  logic        flush,
  output logic        d_valid,
  output logic        d_ready,
  output logic [63:0] d_rdata,
  output logic        stall,
  mmio_ctrl_if.master bus,
  output logic        bus_fault
);

  mmio_state_t state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  be_q, be_d;
  logic [2:0]  ld_type_q, ld_type_d;
  logic [2:0]  ld_off_q, ld_off_d;
  logic        ld_signed_q, ld_signed_d;
  logic [63:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic        in_window;
  logic        hit;
  logic        is_store;
  logic [2:0]  acc_type;
  logic [7:0]  be_w;
  logic [63:0] wdata_w;
  logic [63:0] ld_ext;
  logic        timeout_hit;

  assign in_window = (req_addr >= MMIO_BASE) && (req_addr < (MMIO_BASE + MMIO_SIZE));
  assign hit       = ((req_load_type | req_store_type) != MEM_NONE) && in_window;
  assign is_store  = (req_store_type != MEM_NONE);
  assign acc_type  = is_store ? req_store_type : req_load_type;

  assign d_valid = hit & ~flush;
  assign d_ready = (state_q == DONE);
  // Gated by reset so the pipeline is released the instant reset asserts.
  assign stall   = reset & ((state_q == DRAIN) ? d_valid : (d_valid & ~d_ready));

  // Load extension uses the request fields captured at issue time; store
  // lane generation works on the live MEM-stage request.
  mmio_extend u_extend (
    .ld_type    (ld_type_q),
    .ld_off     (ld_off_q),
    .ld_signed  (ld_signed_q),
    .ld_raw     (bus.bus_rdata),
    .ld_data    (ld_ext),
    .acc_type   (acc_type),
    .acc_off    (req_addr[2:0]),
    .st_data    (req_wdata),
    .be         (be_w),
    .wdata_lane (wdata_w)
  );

`ifdef MMIO_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  // Counts cycles spent waiting on the bus; zero on the first REQ cycle.
  always_comb begin
    cnt_d = 8'd0;
    if ((state_q == REQ) || (state_q == DRAIN)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = (cnt_q == TIMEOUT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    ld_type_d   = ld_type_q;
    ld_off_d    = ld_off_q;
    ld_signed_d = ld_signed_q;
    rdata_d     = rdata_q;
    fault_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_valid) begin
          state_d     = REQ;
          req_d       = 1'b1;
          we_d        = is_store;
          addr_d      = {req_addr[63:3], 3'b000};
          wdata_d     = wdata_w;
          be_d        = be_w;
          ld_type_d   = is_store ? MEM_NONE : req_load_type;
          ld_off_d    = req_addr[2:0];
          ld_signed_d = req_signed;
        end
      end

      REQ: begin
        if (bus.bus_ack) begin
          req_d = 1'b0;
          if (flush) begin
            state_d = IDLE;
          end else if (bus.bus_err) begin
            rdata_d = {64{1'b1}};
            fault_d = 1'b1;
            state_d = DONE;
          end else begin
            rdata_d = ld_ext;
            state_d = DONE;
          end
        end else if (timeout_hit) begin
          req_d = 1'b0;
          if (flush) begin
            // Instruction is gone; nobody to report the fault to.
            state_d = IDLE;
          end else begin
            rdata_d = {64{1'b1}};
            fault_d = 1'b1;
            state_d = DONE;
          end
        end else if (flush) begin
          state_d = DRAIN;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      DRAIN: begin
        if (bus.bus_ack || timeout_hit) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 64'd0;
      wdata_q     <= 64'd0;
      be_q        <= 8'd0;
      ld_type_q   <= MEM_NONE;
      ld_off_q    <= 3'd0;
      ld_signed_q <= 1'b0;
      rdata_q     <= 64'd0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      ld_type_q   <= ld_type_d;
      ld_off_q    <= ld_off_d;
      ld_signed_q <= ld_signed_d;
      rdata_q     <= rdata_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_be    = be_q;
  assign d_rdata       = rdata_q;
  // Registered: the pulse coincides with the DONE cycle of the faulting access.
  assign bus_fault     = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_ctrl.sv
//==============================================================================
// Module   : tb_mmio_ctrl
// Purpose  : Self-checking bench for mmio_ctrl with a transaction-level model.
// Config   : MMIO_TIMEOUT_EN selects the timeout expectations.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mmio_ctrl;
  import mmio_ctrl_pkg::*;

  localparam logic [63:0] MMIO_BASE = 64'h0000_2000;
  localparam logic [63:0] MMIO_SIZE = 64'h0000_1000;
  localparam int          TIMEOUT   = 16;
`ifdef MMIO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [2:0]  req_load_type = '0;
  logic [2:0]  req_store_type = '0;
  logic        req_signed = 1'b0;
  logic        flush = 1'b0;
  logic        d_valid, d_ready, stall, bus_fault;
  logic [63:0] d_rdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] obs_rdata;

  mmio_ctrl_if bus_if ();

  mmio_ctrl #(.MMIO_BASE(MMIO_BASE), .MMIO_SIZE(MMIO_SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clock          (clk),
    .reset          (rst_n),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_load_type  (req_load_type),
    .req_store_type (req_store_type),
    .req_signed     (req_signed),
    .flush          (flush),
    .d_valid        (d_valid),
    .d_ready        (d_ready),
    .d_rdata        (d_rdata),
    .stall          (stall),
    .bus            (bus_if),
    .bus_fault      (bus_fault)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int size_bytes(input logic [2:0] t);
    case (t)
      3'd1: return 1;
      3'd2: return 2;
      3'd3: return 4;
      3'd4: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] width_mask(input int nbytes);
    if (nbytes >= 8) return {64{1'b1}};
    return (64'd1 << (8 * nbytes)) - 64'd1;
  endfunction

  // Reference load result: take nbytes starting at byte 'off', then extend.
  function automatic logic [63:0] model_load(input logic [63:0] raw, input int off,
                                             input int nbytes, input logic sgn);
    logic [63:0] v;
    logic [63:0] m;
    m = width_mask(nbytes);
    v = (raw >> (8 * off)) & m;
    if (sgn && nbytes > 0 && v[8*nbytes-1]) v = v | ~m;
    return v;
  endfunction

  task automatic set_req(input logic [63:0] a, input logic [2:0] lt, input logic [2:0] st,
                         input logic sgn, input logic [63:0] wd);
    req_addr = a; req_load_type = lt; req_store_type = st; req_signed = sgn; req_wdata = wd;
  endtask

  task automatic clear_req();
    req_load_type = MEM_NONE; req_store_type = MEM_NONE;
  endtask

  // One scripted cycle: check at negedge, then advance to just after posedge.
  task automatic expect_cycle(input string tag, input logic e_stall, input logic e_req,
                              input logic e_ready, input logic [63:0] e_addr);
    @(negedge clk);
    check_val({tag, ".stall"}, stall, e_stall);
    check_val({tag, ".req"}, bus_if.bus_req, e_req);
    check_val({tag, ".ready"}, d_ready, e_ready);
    check_val({tag, ".fault"}, bus_fault, 1'b0);
    if (e_req) check_val({tag, ".addr"}, bus_if.bus_addr, e_addr);
    obs_rdata = d_rdata;
    @(posedge clk); #1;
  endtask

  // Complete MEM-stage access; slave acks on REQ cycle number dly+1.
  // Called just after a posedge with the controller idle.
  task automatic run_txn(input string tag, input logic [63:0] addr, input logic [2:0] lt,
                         input logic [2:0] st, input logic sgn, input logic [63:0] wd,
                         input int dly, input logic err, input logic [63:0] rd,
                         output logic [63:0] got_rdata, output int got_stall,
                         output logic [7:0] got_be, output logic [63:0] got_wdata);
    logic        hit, timed_out, fault_exp, is_load;
    int          off, nbytes, req_cycles, ready_idx, last, fault_cnt, be_int;
    logic [7:0]  exp_be;
    logic [63:0] be_mask, exp_w, exp_data;

    hit       = ((lt != 0) || (st != 0)) && (addr >= MMIO_BASE) && (addr < MMIO_BASE + MMIO_SIZE);
    is_load   = (st == 0) && (lt != 0);
    off       = int'(addr[2:0]);
    nbytes    = size_bytes((st != 0) ? st : lt);
    be_int    = ((1 << nbytes) - 1) << off;
    exp_be    = be_int[7:0];
    be_mask   = '0;
    for (int i = 0; i < 8; i++) be_mask[i*8 +: 8] = {8{exp_be[i]}};
    exp_w     = (wd & width_mask(nbytes)) << (8 * off);
    timed_out = TO_EN && (dly + 1 > TIMEOUT);
    req_cycles = timed_out ? TIMEOUT : dly + 1;
    fault_exp = timed_out || err;
    exp_data  = fault_exp ? {64{1'b1}} : model_load(rd, off, size_bytes(lt), sgn);
    ready_idx = req_cycles + 1;
    last      = hit ? ready_idx : 1;
    fault_cnt = 0; got_stall = 0; got_be = '0; got_wdata = '0; got_rdata = '0;

    set_req(addr, lt, st, sgn, wd);
    for (int idx = 0; idx <= last; idx++) begin
      @(negedge clk);
      check_val({tag, ".d_valid"}, d_valid, hit);
      check_val({tag, ".stall"}, stall, hit && idx < ready_idx);
      check_val({tag, ".req"}, bus_if.bus_req, hit && idx >= 1 && idx <= req_cycles);
      check_val({tag, ".ready"}, d_ready, hit && idx == ready_idx);
      if (stall) got_stall++;
      if (bus_fault) fault_cnt++;
      if (hit && idx >= 1 && idx <= req_cycles) begin
        check_val({tag, ".addr"}, bus_if.bus_addr, {addr[63:3], 3'b000});
        check_val({tag, ".we"}, bus_if.bus_we, st != 0);
        if (st != 0) begin
          check_val({tag, ".be"}, bus_if.bus_be, exp_be);
          check_val({tag, ".wdata"}, bus_if.bus_wdata & be_mask, exp_w & be_mask);
        end
        if (idx == 1) begin got_be = bus_if.bus_be; got_wdata = bus_if.bus_wdata; end
      end
      if (hit && idx == ready_idx) begin
        got_rdata = d_rdata;
        if (is_load || fault_exp) check_val({tag, ".rdata"}, d_rdata, exp_data);
      end
      if (hit && idx == dly + 1 && idx <= req_cycles) begin
        bus_if.bus_ack = 1'b1; bus_if.bus_err = err; bus_if.bus_rdata = rd;
      end
      @(posedge clk); #1;
      bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0;
    end
    check_val({tag, ".fault_cnt"}, 64'(fault_cnt), 64'(hit && fault_exp));
    clear_req();
  endtask

  initial begin
    logic [63:0] g_rd, g_wd, r_addr, rd2;
    int          g_st;
    logic [7:0]  g_be;
    logic [2:0]  r_lt, r_st;
    int          sel;

    bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0; bus_if.bus_rdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.req", bus_if.bus_req, 1'b0);
    check_val("rst.ready", d_ready, 1'b0);
    check_val("rst.rdata", d_rdata, 64'd0);
    check_val("rst.fault", bus_fault, 1'b0);
    check_val("rst.stall", stall, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst1.req", bus_if.bus_req, 1'b0);
    @(posedge clk); #1;

    // Signed word load at 0x2004, ack on the 3rd REQ cycle
    run_txn("lw", 64'h2004, MEM_WORD, MEM_NONE, 1'b1, 64'd0, 2, 1'b0,
            64'h8000_0001_0000_0000, g_rd, g_st, g_be, g_wd);
    check_val("lw.value", g_rd, 64'hFFFF_FFFF_8000_0001);
    check_val("lw.stall_len", 64'(g_st), 64'd4);

    // Byte store 0xA5 at 0x2003
    run_txn("sb", 64'h2003, MEM_NONE, MEM_BYTE, 1'b0, 64'hFFFF_FFFF_FFFF_FFA5, 0, 1'b0,
            64'd0, g_rd, g_st, g_be, g_wd);
    check_val("sb.be", g_be, 8'b0000_1000);
    check_val("sb.lane", {56'd0, g_wd[31:24]}, 64'hA5);

    // Window boundaries
    run_txn("dmem", 64'h1FF8, MEM_DWORD, MEM_NONE, 1'b0, 64'd0, 0, 1'b0, 64'd0, g_rd, g_st, g_be, g_wd);
    check_val("dmem.stall_len", 64'(g_st), 64'd0);
    run_txn("top", 64'h3000, MEM_BYTE, MEM_NONE, 1'b0, 64'd0, 0, 1'b0, 64'd0, g_rd, g_st, g_be, g_wd);
    run_txn("last", 64'h2FFF, MEM_BYTE, MEM_NONE, 1'b1, 64'd0, 1, 1'b0,
            64'h8000_0000_0000_0000, g_rd, g_st, g_be, g_wd);
    run_txn("err", 64'h2000, MEM_DWORD, MEM_NONE, 1'b0, 64'd0, 1, 1'b1, 64'h1234, g_rd, g_st, g_be, g_wd);

    // Long wait without ack: aborts when the timeout is built in
    run_txn("tmo", 64'h2FF8, MEM_DWORD, MEM_NONE, 1'b0, 64'd0, 40, 1'b0,
            64'h0123_4567_89AB_CDEF, g_rd, g_st, g_be, g_wd);
`ifdef MMIO_TIMEOUT_EN
    check_val("tmo.ones", g_rd, {64{1'b1}});
    check_val("tmo.stall_len", 64'(g_st), 64'd17);
`endif

    // Flush in 2nd REQ cycle, new hit arrives during DRAIN
    rd2 = 64'h0000_0000_F000_0042;
    set_req(64'h2000, MEM_DWORD, MEM_NONE, 1'b0, 64'd0);
    expect_cycle("fl0", 1'b1, 1'b0, 1'b0, 64'h2000);
    expect_cycle("fl1", 1'b1, 1'b1, 1'b0, 64'h2000);
    flush = 1'b1;
    expect_cycle("fl2", 1'b0, 1'b1, 1'b0, 64'h2000);
    flush = 1'b0;
    set_req(64'h2010, MEM_WORD, MEM_NONE, 1'b1, 64'd0);
    expect_cycle("fl3", 1'b1, 1'b1, 1'b0, 64'h2000);
    expect_cycle("fl4", 1'b1, 1'b1, 1'b0, 64'h2000);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    expect_cycle("fl5", 1'b1, 1'b1, 1'b0, 64'h2000);
    bus_if.bus_ack = 1'b0;
    expect_cycle("fl6", 1'b1, 1'b0, 1'b0, 64'h2010);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rd2;
    expect_cycle("fl7", 1'b1, 1'b1, 1'b0, 64'h2010);
    bus_if.bus_ack = 1'b0;
    expect_cycle("fl8", 1'b0, 1'b0, 1'b1, 64'h2010);
    check_val("fl8.rdata", obs_rdata, model_load(rd2, 0, 4, 1'b1));
    clear_req();

    // Flush coinciding with ack: response dropped, back to idle
    set_req(64'h2100, MEM_BYTE, MEM_NONE, 1'b0, 64'd0);
    expect_cycle("fa0", 1'b1, 1'b0, 1'b0, 64'h2100);
    flush = 1'b1; bus_if.bus_ack = 1'b1; bus_if.bus_err = 1'b1;
    expect_cycle("fa1", 1'b0, 1'b1, 1'b0, 64'h2100);
    flush = 1'b0; bus_if.bus_ack = 1'b0; bus_if.bus_err = 1'b0;
    clear_req();
    expect_cycle("fa2", 1'b0, 1'b0, 1'b0, 64'h0);
    expect_cycle("fa3", 1'b0, 1'b0, 1'b0, 64'h0);

    // Reset asserted while in REQ
    set_req(64'h2008, MEM_HALF, MEM_NONE, 1'b0, 64'd0);
    expect_cycle("rs0", 1'b1, 1'b0, 1'b0, 64'h2008);
    @(negedge clk);
    check_val("rs1.req", bus_if.bus_req, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_val("rsa.req", bus_if.bus_req, 1'b0);
    check_val("rsa.stall", stall, 1'b0);
    check_val("rsa.ready", d_ready, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_req();
    expect_cycle("rs2", 1'b0, 1'b0, 1'b0, 64'h0);
    run_txn("post_rst", 64'h200A, MEM_HALF, MEM_NONE, 1'b1, 64'd0, 0, 1'b0,
            64'h0000_8001_0000_0000, g_rd, g_st, g_be, g_wd);

    // Randomised accesses
    for (int t = 0; t < 40; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel == 0) r_addr = ($urandom_range(0, 1) == 0) ? 64'h1000 + 64'($urandom_range(0, 4095))
                                                        : 64'h3000 + 64'($urandom_range(0, 4095));
      else          r_addr = MMIO_BASE + 64'($urandom_range(0, 4095));
      sel = int'($urandom_range(0, 7));
      r_lt = MEM_NONE; r_st = MEM_NONE;
      if (sel >= 1 && sel <= 3) r_st = 3'($urandom_range(1, 4));
      else if (sel >= 4)        r_lt = 3'($urandom_range(1, 4));
      run_txn("rnd", r_addr, r_lt, r_st, 1'($urandom_range(0, 1)), {$urandom, $urandom},
              int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0), {$urandom, $urandom},
              g_rd, g_st, g_be, g_wd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
